ahb_cpu_manager: RTL and testbench

//  AHB-Lite single manager between the CPU memory-request interface (ahb_controller_if)
//  and the system AHB bus (ahb_bus_if); feeds ahb_multiplexor -> satellites (default, GNSS, ...).

---
 rtl/ahb_cpu_manager_pkg.sv | 36 +++
 rtl/ahb_cpu_manager.sv | 128 ++++++++++++
 tb/tb_ahb_cpu_manager.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_cpu_manager_pkg.sv
// Shared types for the CPU-side AHB-Lite manager: bus encodings and FSM states.
package ahb_cpu_manager_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA_I,
    ST_DATA_D
  } state_t;

  // dwrite code 00 (read) also maps to a word transfer
  function automatic hsize_t dwrite_to_hsize(input logic [1:0] dw);
    case (dw)
      2'b01:   return HSIZE_BYTE;
      2'b10:   return HSIZE_HALF;
      default: return HSIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/ahb_cpu_manager.sv
// AHB-Lite single manager: turns CPU instruction/data requests into single AHB
// transfers, data taking priority over instruction fetch.
module ahb_cpu_manager
  import ahb_cpu_manager_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_iread,
  input  logic        i_dread,
  input  logic [1:0]  i_dwrite,
  input  logic [31:0] i_iaddr,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dstore,
  output logic        o_ihit,
  output logic        o_dhit,
  output logic [31:0] o_iload,
  output logic [31:0] o_dload,
  output logic [31:0] o_haddr,
  output logic [1:0]  o_htrans,
  output logic        o_hwrite,
  output logic [2:0]  o_hsize,
  output logic [2:0]  o_hburst,
  output logic [31:0] o_hwdata,
  input  logic [31:0] i_hrdata,
  input  logic        i_hready,
  input  logic        i_hresp
);

  state_t     r_state;
  logic       r_ipend;
  logic       r_dpend;
  logic [1:0] r_pdw;
  logic       r_dwr;
  word_t      r_hwdata;
  word_t      r_iload;
  word_t      r_dload;

  logic       w_dreq;
  logic       w_ireq;
  logic [1:0] w_dw;
  logic       w_issue_d;
  logic       w_issue_i;
  logic       w_ihit;
  logic       w_dhit;
  word_t      w_rdata;

  // Request pulses are single-cycle, so a request stalled by hready=0 or
  // beaten by a data request is remembered in r_dpend/r_ipend.
  always_comb begin
    w_dw      = r_dpend ? r_pdw : i_dwrite;
    w_dreq    = i_dread | (i_dwrite != 2'b00) | r_dpend;
    w_ireq    = i_iread | r_ipend;
    w_issue_d = (r_state == ST_IDLE) && w_dreq;
    w_issue_i = (r_state == ST_IDLE) && !w_dreq && w_ireq;
    w_ihit    = (r_state == ST_DATA_I) && i_hready;
    w_dhit    = (r_state == ST_DATA_D) && i_hready;
    w_rdata   = i_hresp ? '0 : i_hrdata;

    o_htrans  = HTRANS_IDLE;
    o_haddr   = '0;
    o_hwrite  = 1'b0;
    o_hsize   = HSIZE_WORD;
    if (w_issue_d) begin
      o_htrans = HTRANS_NONSEQ;
      o_haddr  = i_daddr;
      o_hwrite = (w_dw != 2'b00);
      o_hsize  = dwrite_to_hsize(w_dw);
    end else if (w_issue_i) begin
      o_htrans = HTRANS_NONSEQ;
      o_haddr  = i_iaddr;
    end

    o_ihit   = w_ihit;
    o_dhit   = w_dhit;
    o_iload  = w_ihit ? w_rdata : r_iload;
    o_dload  = (w_dhit && !r_dwr) ? w_rdata : r_dload;
    o_hburst = HBURST_SINGLE;
    o_hwdata = r_hwdata;
  end

  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_state  <= ST_IDLE;
      r_ipend  <= 1'b0;
      r_dpend  <= 1'b0;
      r_pdw    <= 2'b00;
      r_dwr    <= 1'b0;
      r_hwdata <= '0;
      r_iload  <= '0;
      r_dload  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue_d) begin
            r_ipend <= w_ireq;
            if (i_hready) begin
              r_state <= ST_DATA_D;
              r_dpend <= 1'b0;
              r_dwr   <= (w_dw != 2'b00);
              if (w_dw != 2'b00) r_hwdata <= i_dstore;
            end else begin
              r_dpend <= 1'b1;
              r_pdw   <= w_dw;
            end
          end else if (w_issue_i) begin
            if (i_hready) begin
              r_state <= ST_DATA_I;
              r_ipend <= 1'b0;
              r_dwr   <= 1'b0;
            end else begin
              r_ipend <= 1'b1;
            end
          end
        end
        ST_DATA_I, ST_DATA_D: begin
          r_ipend <= r_ipend | i_iread;
          if (i_hready) begin
            r_state <= ST_IDLE;
            if (r_state == ST_DATA_I) r_iload <= w_rdata;
            else if (!r_dwr)          r_dload <= w_rdata;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_cpu_manager.sv
// Bench for ahb_cpu_manager: directed scenarios plus randomized transfers,
// with a small satellite model driving the AHB response side.
module tb_ahb_cpu_manager;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_iread, i_dread;
  logic [1:0]  i_dwrite;
  logic [31:0] i_iaddr, i_daddr, i_dstore;
  logic        o_ihit, o_dhit;
  logic [31:0] o_iload, o_dload, o_haddr;
  logic [1:0]  o_htrans;
  logic        o_hwrite;
  logic [2:0]  o_hsize, o_hburst;
  logic [31:0] o_hwdata;
  logic [31:0] i_hrdata;
  logic        i_hready, i_hresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_iload, exp_dload;
  logic [31:0] sat_reg [2];

  ahb_cpu_manager dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_iread(i_iread), .i_dread(i_dread), .i_dwrite(i_dwrite),
    .i_iaddr(i_iaddr), .i_daddr(i_daddr), .i_dstore(i_dstore),
    .o_ihit(o_ihit), .o_dhit(o_dhit), .o_iload(o_iload), .o_dload(o_dload),
    .o_haddr(o_haddr), .o_htrans(o_htrans), .o_hwrite(o_hwrite),
    .o_hsize(o_hsize), .o_hburst(o_hburst), .o_hwdata(o_hwdata),
    .i_hrdata(i_hrdata), .i_hready(i_hready), .i_hresp(i_hresp)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_sat(input logic [31:0] a);
    return a[31:3] == 29'h0000_8000;
  endfunction

  // Satellite: reg0 is write-1-to-clear, reg1 is plain read/write
  function automatic logic [31:0] sat_read(input logic [31:0] a);
    return sat_reg[a[2]];
  endfunction

  task automatic sat_write(input logic [31:0] a, input logic [31:0] d);
    if (a[2] == 1'b0) sat_reg[0] = sat_reg[0] & ~d;
    else              sat_reg[1] = d;
  endtask

  // One complete transfer starting just after a rising edge and ending just
  // after a rising edge. aw = address-phase wait cycles, waits = data-phase waits.
  task automatic xfer(input bit isd, input logic [1:0] dw, input logic [31:0] addr,
                      input logic [31:0] store, input int aw, input int waits, input bit err);
    logic [31:0] rd;
    logic [2:0]  esize;
    bit          wr;
    int          nw;
    wr    = isd && (dw != 2'b00);
    nw    = (err && waits == 0) ? 1 : waits;
    rd    = is_sat(addr) ? sat_read(addr) : $urandom;
    esize = wr ? ({1'b0, dw} - 3'd1) : 3'd2;
    if (isd) begin
      i_dread = !wr; i_dwrite = dw; i_daddr = addr; i_dstore = store;
    end else begin
      i_iread = 1'b1; i_iaddr = addr;
    end
    for (int a = 0; a <= aw; a++) begin
      i_hready = (a == aw);
      i_hresp  = 1'b0;
      @(negedge i_clk);
      chk("addr_htrans", o_htrans, 2'b10);
      chk("addr_haddr", o_haddr, addr);
      chk("addr_hwrite", o_hwrite, wr);
      chk("addr_hsize", o_hsize, esize);
      chk("addr_hburst", o_hburst, 3'b000);
      @(posedge i_clk); #1;
      i_iread = 1'b0; i_dread = 1'b0; i_dwrite = 2'b00;
    end
    for (int w = 0; w <= nw; w++) begin
      if (w < nw) begin
        i_hready = 1'b0; i_hresp = err && (w == nw - 1); i_hrdata = $urandom;
      end else begin
        i_hready = 1'b1; i_hresp = err; i_hrdata = rd;
      end
      @(negedge i_clk);
      chk("data_ihit", o_ihit, !isd && (w == nw));
      chk("data_dhit", o_dhit, isd && (w == nw));
      chk("data_htrans", o_htrans, 2'b00);
      if (wr) chk("data_hwdata", o_hwdata, store);
      if (w == nw) begin
        if (!isd)    chk("done_iload", o_iload, err ? 32'h0 : rd);
        else if (!wr) chk("done_dload", o_dload, err ? 32'h0 : rd);
        else         chk("done_dload_wr", o_dload, exp_dload);
      end
      @(posedge i_clk); #1;
    end
    if (!isd)     exp_iload = err ? 32'h0 : rd;
    else if (!wr) exp_dload = err ? 32'h0 : rd;
    else if (!err && is_sat(addr) && dw == 2'b11) sat_write(addr, store);
    i_hready = 1'b1; i_hresp = 1'b0; i_hrdata = $urandom;
    @(negedge i_clk);
    chk("post_ihit", o_ihit, 1'b0);
    chk("post_dhit", o_dhit, 1'b0);
    chk("post_iload", o_iload, exp_iload);
    chk("post_dload", o_dload, exp_dload);
    chk("post_htrans", o_htrans, 2'b00);
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic [31:0] rd_d, rd_i;
    i_nrst = 1'b1;
    i_iread = 1'b0; i_dread = 1'b0; i_dwrite = 2'b00;
    i_iaddr = '0; i_daddr = '0; i_dstore = '0;
    i_hrdata = 32'hdead_beef; i_hready = 1'b1; i_hresp = 1'b0;
    exp_iload = '0; exp_dload = '0;
    sat_reg[0] = '0; sat_reg[1] = '0;

    // Reset values, during and after reset
    @(negedge i_clk);
    chk("rst_htrans", o_htrans, 2'b00);
    chk("rst_ihit", o_ihit, 1'b0);
    chk("rst_dhit", o_dhit, 1'b0);
    chk("rst_iload", o_iload, 32'h0);
    chk("rst_dload", o_dload, 32'h0);
    chk("rst_haddr", o_haddr, 32'h0);
    chk("rst_hwrite", o_hwrite, 1'b0);
    chk("rst_hsize", o_hsize, 3'b010);
    chk("rst_hwdata", o_hwdata, 32'h0);
    @(posedge i_clk); #1;
    i_nrst = 1'b0;
    @(negedge i_clk);
    chk("postrst_htrans", o_htrans, 2'b00);
    chk("postrst_dload", o_dload, 32'h0);
    @(posedge i_clk); #1;

    // Satellite register scenarios
    xfer(1'b1, 2'b00, 32'h0004_0000, 32'h0, 0, 0, 1'b0);
    xfer(1'b1, 2'b11, 32'h0004_0004, 32'h1, 0, 0, 1'b0);
    xfer(1'b1, 2'b00, 32'h0004_0004, 32'h0, 0, 0, 1'b0);
    sat_reg[0] = 32'h0000_2139;
    xfer(1'b1, 2'b00, 32'h0004_0000, 32'h0, 0, 0, 1'b0);
    chk("reg0_read", exp_dload, 32'h0000_2139);
    xfer(1'b1, 2'b11, 32'h0004_0000, 32'h39, 0, 1, 1'b0);
    xfer(1'b1, 2'b00, 32'h0004_0000, 32'h0, 0, 0, 1'b0);
    chk("reg0_after_clear", o_dload, 32'h0000_2100);

    // Instruction fetch with two wait states, address-phase stall, sub-word writes
    xfer(1'b0, 2'b00, 32'h0000_0000, 32'h0, 0, 2, 1'b0);
    xfer(1'b0, 2'b00, 32'h0000_0100, 32'h0, 2, 0, 1'b0);
    xfer(1'b1, 2'b01, 32'h0004_0005, 32'h0000_00a5, 1, 0, 1'b0);
    xfer(1'b1, 2'b10, 32'h0004_0006, 32'h0000_5a5a, 0, 1, 1'b0);

    // ERROR responses on data read, data write and instruction fetch
    xfer(1'b1, 2'b00, 32'h0004_0004, 32'h0, 0, 1, 1'b1);
    xfer(1'b1, 2'b11, 32'h0004_0004, 32'h7, 0, 0, 1'b1);
    xfer(1'b0, 2'b00, 32'h0000_0040, 32'h0, 0, 2, 1'b1);

    // Simultaneous iread + dread: data first, instruction issued right after dhit
    rd_d = $urandom; rd_i = $urandom;
    i_iread = 1'b1; i_iaddr = 32'h0000_0200;
    i_dread = 1'b1; i_daddr = 32'h1000_0010;
    i_hready = 1'b1;
    @(negedge i_clk);
    chk("sim_htrans", o_htrans, 2'b10);
    chk("sim_haddr_d", o_haddr, 32'h1000_0010);
    @(posedge i_clk); #1;
    i_iread = 1'b0; i_dread = 1'b0; i_hrdata = rd_d;
    @(negedge i_clk);
    chk("sim_dhit", o_dhit, 1'b1);
    chk("sim_ihit_lo", o_ihit, 1'b0);
    chk("sim_dload", o_dload, rd_d);
    @(posedge i_clk); #1;
    exp_dload = rd_d;
    i_hrdata = $urandom;
    @(negedge i_clk);
    chk("sim_htrans_i", o_htrans, 2'b10);
    chk("sim_haddr_i", o_haddr, 32'h0000_0200);
    chk("sim_dhit_lo", o_dhit, 1'b0);
    @(posedge i_clk); #1;
    i_hrdata = rd_i;
    @(negedge i_clk);
    chk("sim_ihit", o_ihit, 1'b1);
    chk("sim_iload", o_iload, rd_i);
    @(posedge i_clk); #1;
    exp_iload = rd_i;
    i_hrdata = $urandom;
    @(negedge i_clk);
    chk("sim_idle", o_htrans, 2'b00);
    chk("sim_iload_hold", o_iload, exp_iload);
    chk("sim_dload_hold", o_dload, exp_dload);
    @(posedge i_clk); #1;

    // Randomized transfers away from the satellite
    for (int n = 0; n < 40; n++) begin
      bit          r_isd;
      logic [1:0]  r_dw;
      logic [31:0] r_addr;
      r_isd  = 1'($urandom_range(0, 1));
      r_dw   = r_isd ? 2'($urandom_range(0, 3)) : 2'b00;
      r_addr = {4'h1, 28'($urandom)};
      xfer(r_isd, r_dw, r_addr, $urandom, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of a data phase: no hit, everything back to reset values
    i_dread = 1'b1; i_daddr = 32'h1000_0020; i_hready = 1'b1;
    @(posedge i_clk); #1;
    i_dread = 1'b0; i_hready = 1'b0;
    i_nrst = 1'b1;
    #1;
    chk("midrst_dhit", o_dhit, 1'b0);
    chk("midrst_htrans", o_htrans, 2'b00);
    chk("midrst_dload", o_dload, 32'h0);
    chk("midrst_iload", o_iload, 32'h0);
    chk("midrst_hwdata", o_hwdata, 32'h0);
    i_hready = 1'b1;
    @(posedge i_clk); #1;
    i_nrst = 1'b0;
    @(negedge i_clk);
    chk("midrst_after_dhit", o_dhit, 1'b0);
    chk("midrst_after_htrans", o_htrans, 2'b00);
    exp_iload = '0; exp_dload = '0;
    @(posedge i_clk); #1;
    xfer(1'b1, 2'b00, 32'h0004_0004, 32'h0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
